// File: rtl/uart_baud_ctrl.sv
// uart_baud_ctrl: runtime-programmable baud tick generator.
// Produces a 16x oversample tick (s_tick) and a 1x bit tick (b_tick).
// Divisor updates are staged and only take effect on a tick boundary.
// Optional macro UART_BAUD_LOCK_EN: when defined, a staged update waits
// until both the TX and RX cores report idle at the terminal count.
module uart_baud_ctrl #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned MIN_DIV   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_req,
  output logic             cfg_ack,
  output logic             cfg_err,
  input  logic             tx_busy,
  input  logic             rx_busy,
  output logic             s_tick,
  output logic             b_tick,
  output logic [DIV_W-1:0] div_cur,
  output logic             pending
);

  localparam logic [DIV_W-1:0] DIV_RST   = DIV_W'(CLK_FREQ / (BAUD_RATE * 16) - 1);
  localparam logic [DIV_W-1:0] MIN_DIV_V = DIV_W'(MIN_DIV);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt;
  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] div_stg_r;
  logic [3:0]       phase_r;
  logic             term_s;
  logic             lock_s;
  logic             apply_s;
  logic             load_s;
  logic             err_s;

  // Terminal count of the oversample divider: next cycle carries s_tick.
  assign term_s = (cnt_r == div_cur);

`ifdef UART_BAUD_LOCK_EN
  // Only switch rates when neither core is in the middle of a frame.
  assign lock_s = ~tx_busy & ~rx_busy;
`else
  // Busy inputs are kept in the interface but do not gate the update.
  logic unused_busy_s;
  assign unused_busy_s = tx_busy | rx_busy;
  assign lock_s        = 1'b1;
`endif

  // State register for the update handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic: accept/reject requests in IDLE, apply at a boundary in PEND.
  always_comb begin
    state_nxt = state_r;
    apply_s   = 1'b0;
    load_s    = 1'b0;
    err_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (cfg_req) begin
          if (cfg_div < MIN_DIV_V) begin
            err_s     = 1'b1;
            state_nxt = IDLE;
          end else begin
            load_s    = 1'b1;
            state_nxt = PEND;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      PEND: begin
        // Re-requests are silently dropped while an update is staged.
        if (term_s && lock_s) begin
          apply_s   = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = PEND;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Divider, phase counter, divisor registers and registered pulse outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r     <= {DIV_W{1'b0}};
      phase_r   <= 4'd0;
      div_cur   <= DIV_RST;
      div_stg_r <= DIV_RST;
      s_tick    <= 1'b0;
      b_tick    <= 1'b0;
      cfg_ack   <= 1'b0;
      cfg_err   <= 1'b0;
      pending   <= 1'b0;
    end else begin
      s_tick  <= term_s;
      // The boundary b_tick still follows the old phase even when applying.
      b_tick  <= term_s && (phase_r == 4'd15);
      cfg_ack <= apply_s;
      cfg_err <= err_s;
      pending <= (state_nxt == PEND);
      if (term_s) begin
        cnt_r <= {DIV_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
      end
      if (apply_s) begin
        phase_r <= 4'd0;
      end else if (term_s) begin
        phase_r <= phase_r + 4'd1;
      end else begin
        phase_r <= phase_r;
      end
      if (apply_s) begin
        div_cur <= div_stg_r;
      end else begin
        div_cur <= div_cur;
      end
      if (load_s) begin
        div_stg_r <= cfg_div;
      end else begin
        div_stg_r <= div_stg_r;
      end
    end
  end

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Self-checking bench for uart_baud_ctrl: a tick-time model checked every
// cycle plus directed scenarios with hand-computed literal expectations.
module tb_uart_baud_ctrl;

  localparam int DIV_RST = 100_000_000 / (9600 * 16) - 1;
  localparam int MIN_DIV = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cfg_div = 16'd0;
  logic        cfg_req = 1'b0;
  logic        cfg_ack;
  logic        cfg_err;
  logic        tx_busy = 1'b0;
  logic        rx_busy = 1'b0;
  logic        s_tick;
  logic        b_tick;
  logic [15:0] div_cur;
  logic        pending;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  uart_baud_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg_div (cfg_div),
    .cfg_req (cfg_req),
    .cfg_ack (cfg_ack),
    .cfg_err (cfg_err),
    .tx_busy (tx_busy),
    .rx_busy (rx_busy),
    .s_tick  (s_tick),
    .b_tick  (b_tick),
    .div_cur (div_cur),
    .pending (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    chk_cnt++;
    if (act == exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      if (fail_cnt < 40)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- tick-time model ----------------
  // Tracks absolute cycle numbers of the next expected tick instead of a counter.
  int     k       = 0;
  longint t_next  = 0;
  int     n_ticks = 0;
  int     m_div   = DIV_RST;
  int     m_stg   = DIV_RST;
  bit     m_pend  = 1'b0;
  bit     valid   = 1'b0;
  bit     e_s, e_b, e_ack, e_err, e_pend;
  int     e_div;

  always @(negedge clk) begin
    bit term;
    bit apply;
    bit lock_ok;
    if (valid) begin
      check("s_tick",  s_tick,  e_s);
      check("b_tick",  b_tick,  e_b);
      check("cfg_ack", cfg_ack, e_ack);
      check("cfg_err", cfg_err, e_err);
      check("pending", pending, e_pend);
      check("div_cur", div_cur, e_div);
    end
    // Predict the cycle after the coming rising edge from the inputs now applied.
    if (!rst_n) begin
      m_div = DIV_RST; m_stg = DIV_RST; m_pend = 1'b0; n_ticks = 0;
      t_next = k + 1 + DIV_RST + 1;
      e_s = 1'b0; e_b = 1'b0; e_ack = 1'b0; e_err = 1'b0; e_pend = 1'b0;
      e_div = DIV_RST;
      valid = 1'b1;
    end else if (valid) begin
      term = (k + 1 == t_next);
`ifdef UART_BAUD_LOCK_EN
      lock_ok = !tx_busy && !rx_busy;
`else
      lock_ok = 1'b1;
`endif
      apply = m_pend && term && lock_ok;
      e_s   = term;
      e_b   = term && (n_ticks % 16 == 15);
      if (term) n_ticks = apply ? 0 : n_ticks + 1;
      e_ack = apply;
      e_err = !m_pend && cfg_req && (int'(cfg_div) < MIN_DIV);
      if (apply) begin
        m_div  = m_stg;
        m_pend = 1'b0;
      end else if (!m_pend && cfg_req && int'(cfg_div) >= MIN_DIV) begin
        m_stg  = cfg_div;
        m_pend = 1'b1;
      end
      if (term) t_next = k + 1 + m_div + 1;
      e_pend = m_pend;
      e_div  = m_div;
    end
    k++;
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // which: 0 = s_tick, 1 = b_tick, 2 = cfg_ack
  task automatic wait_sig(input int which, input int limit, output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (n < limit && !seen) begin
      step(1);
      n++;
      case (which)
        0:       seen = s_tick;
        1:       seen = b_tick;
        default: seen = cfg_ack;
      endcase
    end
  endtask

  initial begin
    int n;
    int n2;
    bit seen;
    int acks;

    // Reset default
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    check("reset_div_cur", div_cur, 650);
    check("reset_pending", pending, 0);
    check("reset_s_tick", s_tick, 0);
    wait_sig(0, 1000, n, seen);
    check("first_s_tick_seen", seen, 1);
    check("first_s_tick_clocks", n, 651);
    wait_sig(1, 11000, n2, seen);
    check("first_b_tick_seen", seen, 1);
    check("first_b_tick_clocks", n + n2, 10416);

    // Reject: divisor below minimum
    cfg_div = 16'd2; cfg_req = 1'b1;
    step(1);
    cfg_req = 1'b0;
    check("reject_err", cfg_err, 1);
    check("reject_pending", pending, 0);
    step(1);
    check("reject_err_width", cfg_err, 0);
    check("reject_div_cur", div_cur, 650);

    // Rate change to 53 with an ignored re-request of 100
    cfg_div = 16'd53; cfg_req = 1'b1;
    step(1);
    cfg_req = 1'b0;
    check("rate_pending", pending, 1);
    cfg_div = 16'd100; cfg_req = 1'b1;
    step(1);
    cfg_req = 1'b0;
    check("rerequest_no_err", cfg_err, 0);
    wait_sig(2, 700, n, seen);
    check("rate_ack_seen", seen, 1);
    check("rate_ack_with_s_tick", s_tick, 1);
    check("rate_div_cur", div_cur, 53);
    check("rate_pending_clear", pending, 0);
    wait_sig(0, 100, n, seen);
    check("rate_period", n, 54);
    wait_sig(1, 1000, n2, seen);
    check("rate_b_tick_after_ack", n + n2, 864);

    // Lock behaviour: request to the minimum divisor with TX busy
    tx_busy = 1'b1;
    cfg_div = 16'd3; cfg_req = 1'b1;
    step(1);
    cfg_req = 1'b0;
`ifdef UART_BAUD_LOCK_EN
    acks = 0;
    repeat (5 * 54) begin
      step(1);
      if (cfg_ack) acks++;
    end
    check("lock_no_ack_while_busy", acks, 0);
    check("lock_pending_held", pending, 1);
    tx_busy = 1'b0;
`endif
    wait_sig(2, 56, n, seen);
    check("lock_ack_seen", seen, 1);
    check("lock_div_cur", div_cur, 3);
    tx_busy = 1'b0;
    wait_sig(0, 10, n, seen);
    check("min_div_period", n, 4);
    step(100);

    // Reset while an update is pending
    cfg_div = 16'd100; cfg_req = 1'b1;
    step(1);
    cfg_req = 1'b0;
    check("mid_pending_set", pending, 1);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    check("mid_reset_pending", pending, 0);
    check("mid_reset_div_cur", div_cur, 650);
    acks = 0;
    repeat (1400) begin
      step(1);
      if (cfg_ack) acks++;
    end
    check("mid_reset_no_ack", acks, 0);
    check("mid_reset_div_kept", div_cur, 650);

    step(2);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/uart_baud_ctrl.md
# uart_baud_ctrl

- Runtime-programmable baud tick controller for the UART. Replaces the fixed compile-time divisor with a staged divisor register and a safe-update handshake.
- Generates the 16x oversampling tick (`s_tick`) for RX/TX bit timing and a 1x bit tick (`b_tick`).
- Sits between the host/config logic and the UART TX/RX cores.
- Divisor changes take effect only on a tick boundary, optionally only while both cores are idle.

## Interface

Parameters:
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 9600: reset baud rate. Reset divisor `DIV_RST` = `CLK_FREQ/(BAUD_RATE*16) - 1` (650 at defaults).
- `DIV_W`, 16: divisor and counter width.
- `MIN_DIV`, 3: smallest accepted divisor.

Ports:
- `clk` in 1: the only clock. All logic is on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `cfg_div` in DIV_W: requested terminal count. Tick period is `cfg_div+1` clocks.
- `cfg_req` in 1: single-cycle update request. Sampled only in IDLE.
- `cfg_ack` out 1: one-cycle pulse when the new divisor becomes active.
- `cfg_err` out 1: one-cycle pulse when a request is rejected.
- `tx_busy` in 1: TX core mid-frame.
- `rx_busy` in 1: RX core mid-frame.
- `s_tick` out 1: 16x oversample pulse, one clock wide.
- `b_tick` out 1: bit pulse, one clock wide. Coincides with every 16th `s_tick`.
- `div_cur` out DIV_W: active divisor.
- `pending` out 1: high while a staged update waits.

## Operation

- **Tick counter.** `cnt` counts 0..`div_cur`.
  - When `cnt == div_cur`: `cnt` clears to 0 and `s_tick` is registered high for the next cycle. Otherwise `cnt` increments and `s_tick` is low.
- **Phase counter.** 4-bit `phase` increments on each `s_tick` cycle.
  - `b_tick` is high in the same cycle as `s_tick` when `phase == 15`. `phase` then wraps to 0.
- **FSM.**
  - IDLE:
    - `cfg_req` with `cfg_div < MIN_DIV`: `cfg_err` pulses next cycle; stay in IDLE.
    - `cfg_req` with a valid `cfg_div`: latch it into `div_stg` and go to PEND.
  - PEND: `pending`=1. Further `cfg_req` is ignored (no ack, no err).
    - Apply condition: `cnt == div_cur` AND lock condition (see Configuration).
    - On apply: next cycle `div_cur` <= `div_stg`, `cnt` <= 0, `phase` <= 0, `cfg_ack`=1, `pending`=0, state returns to IDLE.
    - The `s_tick` for that boundary is still emitted. `b_tick` in that cycle follows the old `phase`.
  - Apply condition false at the terminal count: the counter wraps normally and PEND continues.
- **Arithmetic.** All counters are unsigned and wrap naturally. No divisor value above `MIN_DIV` is special-cased.
- **Reset** (`rst_n`=0 at a rising edge, any state):
  - `cnt`=0, `phase`=0, `div_cur`=`DIV_RST`, `div_stg`=`DIV_RST`, state IDLE.
  - Outputs: `s_tick`=0, `b_tick`=0, `cfg_ack`=0, `cfg_err`=0, `pending`=0.
  - A pending update is discarded with no ack.

## Timing

- After reset release, the first `s_tick` occurs `div_cur+1` clocks later. Steady period is `div_cur+1` clocks.
- `b_tick` period is `16*(div_cur+1)` clocks.
- Request to `cfg_err`: 1 clock.
- Request to `pending`: 1 clock.
- `cfg_ack` coincides with the boundary `s_tick`. The first tick at the new rate comes `div_stg+1` clocks after `cfg_ack`.
- Worst-case ack latency without lock: `div_cur+2` clocks.
- `cfg_req` and apply in the same cycle cannot overlap, because requests are only accepted in IDLE.
- `cfg_ack`, `cfg_err` and `s_tick` are all registered; none is combinational from any input.

## Configuration

- Macro: `UART_BAUD_LOCK_EN`.
- Defined: the lock condition is `!tx_busy && !rx_busy`, sampled in the terminal-count cycle. The update stays pending across any number of ticks until both cores are idle.
- Undefined: the lock condition is constant true. `tx_busy` and `rx_busy` are ignored, but the ports remain in the interface.

## Test plan

- **Reset default.** `rst_n` low 3 clocks, then high → `div_cur`=650; `s_tick` every 651 clocks; `b_tick` every 10416 clocks; all pulses one clock wide.
- **Rate change.** `cfg_div`=53 with `cfg_req` pulse → `pending`=1 next clock; `cfg_ack` with the next `s_tick`; then ticks every 54 clocks; `phase` restarts so the next `b_tick` comes 864 clocks after ack.
- **Reject.** `cfg_div`=2 → `cfg_err` pulse 1 clock later; `div_cur` stays 650; `pending` stays 0.
- **Ignored re-request.** Second `cfg_req` (`cfg_div`=100) while PEND → no err, no extra ack; the first staged value (53) is applied.
- **Lock** (with `UART_BAUD_LOCK_EN`). `tx_busy`=1 for 5 tick periods after request → `pending` held; ack on the first terminal count after `tx_busy` falls. Without the macro, ack comes at the first boundary regardless.
- **Reset mid-pending.** `rst_n` low while PEND → `pending`=0, `div_cur`=650, no `cfg_ack` ever issued for the discarded request.
